// File: rtl/btn_pkg.sv
// Shared definitions for the multi-channel push-button conditioner:
// FSM encoding, default parameters and the counter-width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StPressed  = 2'd1,
    StLongHeld = 2'd2
  } btn_state_e;

  localparam int unsigned DefNBtn      = 4;
  localparam int unsigned DefTickDiv   = 10000;
  localparam int unsigned DefStableCnt = 8;
  localparam int unsigned DefLongCnt   = 50000;
  localparam int unsigned DefRepeatCnt = 10000;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/btn_debounce_multi_if.sv
// Button pins, repeat enables and conditioned event outputs for N_BTN channels.
interface btn_debounce_multi_if #(
  parameter int unsigned N_BTN = 4
);
  logic [N_BTN-1:0] i_btn;
  logic [N_BTN-1:0] i_repeat_en;
  logic [N_BTN-1:0] o_level;
  logic [N_BTN-1:0] o_press;
  logic [N_BTN-1:0] o_release;
  logic [N_BTN-1:0] o_long;
  logic [N_BTN-1:0] o_repeat;

  modport master (
    output i_btn, i_repeat_en,
    input  o_level, o_press, o_release, o_long, o_repeat
  );

  modport slave (
    input  i_btn, i_repeat_en,
    output o_level, o_press, o_release, o_long, o_repeat
  );
endinterface

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, tick-enabled debounce counter,
// press/hold/repeat FSM and registered one-clk event pulses.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DefStableCnt,
  parameter int unsigned LONG_CNT   = DefLongCnt,
  parameter int unsigned REPEAT_CNT = DefRepeatCnt
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int unsigned SW = cnt_w(STABLE_CNT);
  localparam int unsigned HW = cnt_w(LONG_CNT);
  localparam int unsigned RW = cnt_w(REPEAT_CNT);

  logic [1:0]    sync_q;
  logic          sample;
  logic [SW-1:0] stable_q, stable_d;
  logic          level_q, level_d;
  logic          rise, fall;
  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          long_d, rep_pulse_d;
  logic          press_q, release_q, long_q, rep_pulse_q;

  assign sample = sync_q[1];

  // Any sample agreeing with the current level restarts the stability run.
  always_comb begin
    stable_d = stable_q;
    level_d  = level_q;
    if (i_tick) begin
      if (sample == level_q) begin
        stable_d = '0;
      end else if (stable_q == SW'(STABLE_CNT - 1)) begin
        level_d  = ~level_q;
        stable_d = '0;
      end else begin
        stable_d = stable_q + 1'b1;
      end
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      stable_q    <= '0;
      level_q     <= 1'b0;
      state_q     <= StIdle;
      hold_q      <= '0;
      rep_q       <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
      rep_pulse_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], i_btn};
      stable_q    <= stable_d;
      level_q     <= level_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      rep_q       <= rep_d;
      press_q     <= rise;
      release_q   <= fall;
      long_q      <= long_d;
      rep_pulse_q <= rep_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    rep_d   = rep_q;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StPressed;
          hold_d  = '0;
          rep_d   = '0;
        end
      end
      StPressed: begin
        if (fall) begin
          state_d = StIdle;
          hold_d  = '0;
        end else if (i_tick) begin
          if (hold_q == HW'(LONG_CNT - 1)) begin
            state_d = StLongHeld;
            hold_d  = '0;
            rep_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end
      StLongHeld: begin
        if (fall) begin
          state_d = StIdle;
          rep_d   = '0;
        end else if (i_tick) begin
          rep_d = (rep_q == RW'(REPEAT_CNT - 1)) ? '0 : rep_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        hold_d  = '0;
        rep_d   = '0;
      end
    endcase
  end

  // A release on the same tick suppresses long/repeat.
  always_comb begin
    long_d      = 1'b0;
    rep_pulse_d = 1'b0;
    if (i_tick && !fall) begin
      long_d      = (state_q == StPressed) && (hold_q == HW'(LONG_CNT - 1));
      rep_pulse_d = (state_q == StLongHeld) && (rep_q == RW'(REPEAT_CNT - 1)) && i_repeat_en;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = rep_pulse_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel push-button conditioner: one shared sample-tick generator
// driving an independent debounce/long-press channel per button.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN      = DefNBtn,
  parameter int unsigned TICK_DIV   = DefTickDiv,
  parameter int unsigned STABLE_CNT = DefStableCnt,
  parameter int unsigned LONG_CNT   = DefLongCnt,
  parameter int unsigned REPEAT_CNT = DefRepeatCnt
) (
  input logic                 clk,
  input logic                 rst,
  btn_debounce_multi_if.slave bus
);

  localparam int unsigned TW = cnt_w(TICK_DIV - 1);

  logic [TW-1:0]    tick_cnt_q;
  logic             tick;
  logic [N_BTN-1:0] level, press, rls, lng, rpt;

  // Clock enable, not a clock: high for one cycle every TICK_DIV cycles.
  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CNT (STABLE_CNT),
      .LONG_CNT   (LONG_CNT),
      .REPEAT_CNT (REPEAT_CNT)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_tick      (tick),
      .i_btn       (bus.i_btn[g]),
      .i_repeat_en (bus.i_repeat_en[g]),
      .o_level     (level[g]),
      .o_press     (press[g]),
      .o_release   (rls[g]),
      .o_long      (lng[g]),
      .o_repeat    (rpt[g])
    );
  end

  assign bus.o_level   = level;
  assign bus.o_press   = press;
  assign bus.o_release = rls;
  assign bus.o_long    = lng;
  assign bus.o_repeat  = rpt;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed bench for btn_debounce_multi (2 channels, 4-clk tick, 3-sample
// debounce, 10-tick long press, 4-tick repeat) with hand-derived timings.
module tb_btn_debounce_multi;

  logic clk = 1'b0;
  logic rst;

  btn_debounce_multi_if #(.N_BTN(2)) bus ();

  btn_debounce_multi #(
    .N_BTN      (2),
    .TICK_DIV   (4),
    .STABLE_CNT (3),
    .LONG_CNT   (10),
    .REPEAT_CNT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int t0;
  int ts;
  int wide  = 0;
  int n_press[2], n_rel[2], n_long[2], n_rep[2];
  int t_press[2], t_rel[2], t_long[2], t_rep_first[2], t_rep_last[2];
  logic [9:0] prev_pulse = '0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int all_out();
    return int'({bus.o_level, bus.o_press, bus.o_release, bus.o_long, bus.o_repeat});
  endfunction

  task automatic clear_log();
    for (int c = 0; c < 2; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0; n_rep[c] = 0;
      t_press[c] = -1; t_rel[c] = -1; t_long[c] = -1;
      t_rep_first[c] = -1; t_rep_last[c] = -1;
    end
  endtask

  // One clock: sample #1 after the edge and log every pulse with its cycle.
  task automatic step();
    logic [9:0] cur;
    @(posedge clk);
    #1;
    t++;
    cur = {bus.o_press, bus.o_release, bus.o_long, bus.o_repeat, 2'b00};
    if ((cur & prev_pulse) != '0) wide++;
    prev_pulse = cur;
    for (int c = 0; c < 2; c++) begin
      if (bus.o_press[c])   begin n_press[c]++; t_press[c] = t; end
      if (bus.o_release[c]) begin n_rel[c]++;   t_rel[c]   = t; end
      if (bus.o_long[c])    begin n_long[c]++;  t_long[c]  = t; end
      if (bus.o_repeat[c]) begin
        n_rep[c]++;
        if (t_rep_first[c] < 0) t_rep_first[c] = t;
        t_rep_last[c] = t;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_btn = 2'b11;
    bus.i_repeat_en = 2'b00;
    clear_log();

    // Reset with buttons already high
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_outputs_zero", all_out(), 0);
    end
    rst = 1'b0;
    t0 = t;
    clear_log();
    run(16);
    check("rst_rel_press_cnt", n_press[0], 1);
    check("rst_rel_press_time", t_press[0] - t0, 12);
    check("rst_rel_level", int'(bus.o_level), 3);
    bus.i_btn = 2'b00;
    run(30);
    check("rst_rel_release_cnt", n_rel[0], 1);

    // Bounce rejection
    clear_log();
    for (int k = 0; k < 12; k++) begin
      bus.i_btn[0] = (k % 2 == 0);
      run(5);
    end
    check("bounce_no_press", n_press[0], 0);
    ts = t;
    bus.i_btn[0] = 1'b1;
    run(20);
    check("bounce_press_cnt", n_press[0], 1);
    check("bounce_press_lat_ok",
          int'((t_press[0] - ts >= 11) && (t_press[0] - ts <= 14)), 1);
    bus.i_btn[0] = 1'b0;
    run(30);
    check("bounce_release_cnt", n_rel[0], 1);

    // Short press: release lands on the would-be long tick; release wins
    clear_log();
    bus.i_btn[0] = 1'b1;
    run(40);
    bus.i_btn[0] = 1'b0;
    run(30);
    check("short_press_cnt", n_press[0], 1);
    check("short_release_cnt", n_rel[0], 1);
    check("short_hold_len", t_rel[0] - t_press[0], 40);
    check("short_no_long", n_long[0], 0);

    // Long press with auto-repeat; the 5th repeat collides with release
    clear_log();
    bus.i_repeat_en = 2'b01;
    bus.i_btn[0] = 1'b1;
    run(120);
    bus.i_btn[0] = 1'b0;
    run(60);
    check("long_press_cnt", n_press[0], 1);
    check("long_cnt", n_long[0], 1);
    check("long_delay", t_long[0] - t_press[0], 40);
    check("repeat_cnt", n_rep[0], 4);
    check("repeat_first", t_rep_first[0] - t_long[0], 16);
    check("repeat_last", t_rep_last[0] - t_long[0], 64);
    check("long_release_cnt", n_rel[0], 1);
    check("long_release_time", t_rel[0] - t_press[0], 120);

    // ch1 long-held without repeat while ch0 gets a short press
    clear_log();
    bus.i_btn[1] = 1'b1;
    run(10);
    bus.i_btn[0] = 1'b1;
    run(20);
    bus.i_btn[0] = 1'b0;
    run(70);
    bus.i_btn[1] = 1'b0;
    run(40);
    check("ch1_press_cnt", n_press[1], 1);
    check("ch1_long_cnt", n_long[1], 1);
    check("ch1_long_delay", t_long[1] - t_press[1], 40);
    check("ch1_no_repeat", n_rep[1], 0);
    check("ch1_release_cnt", n_rel[1], 1);
    check("ch0_press_cnt", n_press[0], 1);
    check("ch0_release_cnt", n_rel[0], 1);
    check("ch0_hold_len", t_rel[0] - t_press[0], 20);
    check("ch0_no_long", n_long[0], 0);

    // Reset while ch0 sits in LONG_HELD
    clear_log();
    bus.i_repeat_en = 2'b00;
    bus.i_btn[0] = 1'b1;
    run(60);
    check("midrst_long_reached", n_long[0], 1);
    clear_log();
    rst = 1'b1;
    #1;
    check("midrst_async_zero", all_out(), 0);
    run(3);
    check("midrst_held_zero", all_out(), 0);
    rst = 1'b0;
    t0 = t;
    run(16);
    check("midrst_no_release", n_rel[0], 0);
    check("midrst_press_cnt", n_press[0], 1);
    check("midrst_press_time", t_press[0] - t0, 12);
    bus.i_btn[0] = 1'b0;
    run(30);

    check("pulse_width_one", wide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
